// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the execute-stage ALU: data width, the
//            6-bit ALU control codes, and the control FSM state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  // Shifts
  localparam logic [5:0] ALU_SLL   = 6'b000000;
  localparam logic [5:0] ALU_SRL   = 6'b000010;
  localparam logic [5:0] ALU_SRA   = 6'b000011;
  localparam logic [5:0] ALU_SLLV  = 6'b000100;
  localparam logic [5:0] ALU_SRLV  = 6'b000110;
  localparam logic [5:0] ALU_SRAV  = 6'b000111;
  // HI/LO access
  localparam logic [5:0] ALU_MFHI  = 6'b010000;
  localparam logic [5:0] ALU_MTHI  = 6'b010001;
  localparam logic [5:0] ALU_MFLO  = 6'b010010;
  localparam logic [5:0] ALU_MTLO  = 6'b010011;
  // Multiply / divide
  localparam logic [5:0] ALU_MULT  = 6'b011000;
  localparam logic [5:0] ALU_MULTU = 6'b011001;
  localparam logic [5:0] ALU_DIV   = 6'b011010;
  localparam logic [5:0] ALU_DIVU  = 6'b011011;
  // Arithmetic / logic
  localparam logic [5:0] ALU_ADD   = 6'b100000;
  localparam logic [5:0] ALU_ADDU  = 6'b100001;
  localparam logic [5:0] ALU_SUB   = 6'b100010;
  localparam logic [5:0] ALU_SUBU  = 6'b100011;
  localparam logic [5:0] ALU_AND   = 6'b100100;
  localparam logic [5:0] ALU_OR    = 6'b100101;
  localparam logic [5:0] ALU_XOR   = 6'b100110;
  localparam logic [5:0] ALU_NOR   = 6'b100111;
  localparam logic [5:0] ALU_SLT   = 6'b101010;
  localparam logic [5:0] ALU_SLTU  = 6'b101011;
  localparam logic [5:0] ALU_LUI   = 6'b111000;
  // Branch compares
  localparam logic [5:0] ALU_BEQ   = 6'b110000;
  localparam logic [5:0] ALU_BNE   = 6'b110001;
  localparam logic [5:0] ALU_BGTZ  = 6'b110010;
  localparam logic [5:0] ALU_BLEZ  = 6'b110011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    MD_RUN = 2'd2,
    MD_FIX = 2'd3
  } state_e;

  // MULT/MULTU/DIV/DIVU all live in 0110xx.
  function automatic logic is_muldiv(input logic [5:0] code);
    return code[5:2] == 4'b0110;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Purpose  : Request/response bundle between pipeline control and the ALU.
// Ports    : master = pipeline side (drives request, observes response)
//            slave  = ALU side (observes request, drives response)
// Revision : 1.0  initial release
// ============================================================================
interface alu_exec_unit_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [5:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       shamt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             branch_taken;
  logic             illegal;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, shamt,
    input  in_ready, out_valid, result, zero, overflow, branch_taken, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, shamt,
    output in_ready, out_valid, result, zero, overflow, branch_taken, illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_exec_unit_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : 32-iteration shift-add multiplier / restoring divider sharing one
//            64-bit accumulator and a 6-bit iteration counter. Works on
//            operand magnitudes; hi/lo are the sign-corrected results.
// Ports    : clk, rst_n (sync, active-low), start (load operands),
//            is_signed, is_div, a, b (operands), done (last iteration),
//            hi, lo (final HI/LO values, valid once iterations finish)
// Revision : 1.0  initial release
// ============================================================================
module muldiv_iter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               div_q, div_d;
  logic               neg_lo_q, neg_lo_d;   // negate product / quotient
  logic               neg_hi_q, neg_hi_d;   // negate remainder
  logic               div0_q, div0_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod;

  assign done = busy_q && (cnt_q == CNT_W'(31));

  always_comb begin
    acc_d     = acc_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    div_d     = div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    div0_d    = div0_q;

    mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Multiply: add multiplicand into upper half when LSB set, then shift right.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, divisor_q} : {(WIDTH+1){1'b0}});
    // Divide: trial-subtract divisor from the left-shifted partial remainder.
    // The partial remainder is always below the divisor, so 33 bits suffice
    // and bit 32 of the difference is a clean borrow flag.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_q};

    if (start) begin
      acc_d     = {{WIDTH{1'b0}}, mag_a};
      divisor_d = mag_b;
      cnt_d     = '0;
      busy_d    = 1'b1;
      div_d     = is_div;
      neg_lo_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_d  = is_signed && a[WIDTH-1];
      div0_d    = is_div && (b == '0);
    end else if (busy_q) begin
      if (div_q) begin
        if (!div_trial[WIDTH])
          acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // Sign correction. A zero divisor leaves the magnitude of a in the upper
  // half, so restoring the dividend sign yields HI = a; LO is forced.
  always_comb begin
    prod = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    hi   = prod[2*WIDTH-1:WIDTH];
    lo   = prod[WIDTH-1:0];
    if (div_q) begin
      hi = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      if (div0_q)
        lo = '1;
      else
        lo = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      div_q     <= div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      div0_q    <= div0_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU. Single-cycle ops return a registered result
//            one clock after accept; MULT/DIV run 32 iterations into HI/LO.
// Ports    : clk, rst_n (sync, active-low)
//            bus (slave): in_valid/in_ready/alu_ctrl/op_a/op_b/shamt request,
//            out_valid/result/zero/overflow/branch_taken/illegal response
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);
  import alu_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, br_q, br_d;
  logic             ill_q, ill_d, ov_q, ov_d;

  logic [WIDTH-1:0] sum, diff, sc_result;
  logic             sc_ovf, sc_br, sc_ill, sc_hi_we, sc_lo_we;
  logic             in_ready, accept, md_op, md_start, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  // Ready only in IDLE, and not in the cycle that presents a result, so the
  // result cycle of every op is a busy cycle.
  assign in_ready = (state_q == IDLE) && !ov_q;
  assign accept   = bus.in_valid && in_ready;
  assign md_op    = is_muldiv(bus.alu_ctrl);
  assign md_start = accept && md_op;

  muldiv_iter u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .is_signed (!bus.alu_ctrl[0]),
    .is_div    (bus.alu_ctrl[1]),
    .a         (bus.op_a),
    .b         (bus.op_b),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  // Single-cycle datapath, evaluated on the live request at accept.
  always_comb begin
    sum       = bus.op_a + bus.op_b;
    diff      = bus.op_a - bus.op_b;
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_br     = 1'b0;
    sc_ill    = 1'b0;
    sc_hi_we  = 1'b0;
    sc_lo_we  = 1'b0;
    case (bus.alu_ctrl)
      ALU_ADD: begin
        sc_result = sum;
        sc_ovf    = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      ALU_ADDU: sc_result = sum;
      ALU_SUB: begin
        sc_result = diff;
        sc_ovf    = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                    (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      ALU_SUBU: sc_result = diff;
      ALU_AND:  sc_result = bus.op_a & bus.op_b;
      ALU_OR:   sc_result = bus.op_a | bus.op_b;
      ALU_XOR:  sc_result = bus.op_a ^ bus.op_b;
      ALU_NOR:  sc_result = ~(bus.op_a | bus.op_b);
      ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
      ALU_LUI:  sc_result = {bus.op_b[15:0], 16'h0000};
      ALU_SLL:  sc_result = bus.op_b << bus.shamt;
      ALU_SRL:  sc_result = bus.op_b >> bus.shamt;
      ALU_SRA:  sc_result = $unsigned($signed(bus.op_b) >>> bus.shamt);
      ALU_SLLV: sc_result = bus.op_b << bus.op_a[4:0];
      ALU_SRLV: sc_result = bus.op_b >> bus.op_a[4:0];
      ALU_SRAV: sc_result = $unsigned($signed(bus.op_b) >>> bus.op_a[4:0]);
      ALU_BEQ:  begin sc_result = diff; sc_br = (bus.op_a == bus.op_b); end
      ALU_BNE:  begin sc_result = diff; sc_br = (bus.op_a != bus.op_b); end
      ALU_BGTZ: begin sc_result = diff; sc_br = ($signed(bus.op_a) > 0);  end
      ALU_BLEZ: begin sc_result = diff; sc_br = ($signed(bus.op_a) <= 0); end
      ALU_MFHI: sc_result = hi_q;
      ALU_MFLO: sc_result = lo_q;
      ALU_MTHI: begin sc_result = bus.op_a; sc_hi_we = 1'b1; end
      ALU_MTLO: begin sc_result = bus.op_a; sc_lo_we = 1'b1; end
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: begin
        // handled by the iterative unit
      end
      default:  sc_ill = 1'b1;
    endcase
  end

  // Control FSM and output/HI/LO register updates.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    br_d     = br_q;
    ill_d    = ill_q;
    ov_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (md_op) begin
            state_d = MD_RUN;
          end else begin
            state_d  = EXEC;
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            ovf_d    = sc_ovf;
            br_d     = sc_br;
            ill_d    = sc_ill;
            ov_d     = 1'b1;
            if (sc_hi_we) hi_d = bus.op_a;
            if (sc_lo_we) lo_d = bus.op_a;
          end
        end
      end
      EXEC:   state_d = IDLE;
      MD_RUN: if (md_done) state_d = MD_FIX;
      MD_FIX: begin
        state_d  = IDLE;
        hi_d     = md_hi;
        lo_d     = md_lo;
        result_d = md_lo;
        zero_d   = (md_lo == '0);
        ovf_d    = 1'b0;
        br_d     = 1'b0;
        ill_d    = 1'b0;
        ov_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      br_q     <= br_d;
      ill_q    <= ill_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = ov_q;
  assign bus.result       = result_q;
  assign bus.zero         = zero_q;
  assign bus.overflow     = ovf_q;
  assign bus.branch_taken = br_q;
  assign bus.illegal      = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed self-checking bench for alu_exec_unit.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_exec_unit_if bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a single-cycle op at a negedge; returns at the negedge of T+2.
  task automatic do_sc(input string tag, input logic [5:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    bus.alu_ctrl = ctrl; bus.op_a = a; bus.op_b = b; bus.shamt = sh;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1234_5678; bus.alu_ctrl = 6'b111111;
    @(negedge clk);
    chk({tag, "_ov_t1"}, bus.out_valid, 1);
    chk({tag, "_rdy_t1"}, bus.in_ready, 0);
    @(negedge clk);
    chk({tag, "_rdy_t2"}, bus.in_ready, 1);
  endtask

  // Issue a mult/div op; optionally try to inject a second request while busy.
  // Returns at the negedge of T+35.
  task automatic do_md(input string tag, input logic [5:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b, input bit poke);
    int ov_first;
    int ov_cnt;
    bit rdy_hi;
    bus.alu_ctrl = ctrl; bus.op_a = a; bus.op_b = b; bus.shamt = 5'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a = 32'h0BAD_F00D; bus.op_b = 32'h0000_0001; bus.alu_ctrl = ALU_ADDU;
    ov_first = 0; ov_cnt = 0; rdy_hi = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (poke && k == 5) begin bus.alu_ctrl = ALU_ADD; bus.in_valid = 1'b1; end
      if (k == 6) bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid) begin
        ov_cnt++;
        if (ov_first == 0) ov_first = k;
      end
      if (bus.in_ready) rdy_hi = 1'b1;
    end
    chk({tag, "_ov_cycle"}, ov_first, 34);
    chk({tag, "_ov_count"}, ov_cnt, 1);
    chk({tag, "_rdy_busy"}, rdy_hi, 0);
    @(negedge clk);
    chk({tag, "_rdy_after"}, bus.in_ready, 1);
    chk({tag, "_ov_after"}, bus.out_valid, 0);
  endtask

  initial begin
    int ov_seen;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.alu_ctrl = 6'd0; bus.op_a = '0; bus.op_b = '0; bus.shamt = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.zero, bus.overflow, bus.branch_taken, bus.illegal}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", bus.in_ready, 1);
    do_sc("mflo_rst", ALU_MFLO, 0, 0, 0);
    chk("mflo_rst_res", bus.result, 32'h0);
    chk("mflo_rst_zero", bus.zero, 1);

    // Arithmetic with overflow
    do_sc("add", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 0);
    chk("add_res", bus.result, 32'h8000_0000);
    chk("add_ovf", bus.overflow, 1);
    chk("add_zero", bus.zero, 0);
    do_sc("addu", ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 0);
    chk("addu_res", bus.result, 32'h8000_0000);
    chk("addu_ovf", bus.overflow, 0);
    do_sc("sub", ALU_SUB, 32'h8000_0000, 32'h1, 0);
    chk("sub_res", bus.result, 32'h7FFF_FFFF);
    chk("sub_ovf", bus.overflow, 1);

    // Shifts and compares
    do_sc("sra", ALU_SRA, 32'h0, 32'h8000_0000, 5'd4);
    chk("sra_res", bus.result, 32'hF800_0000);
    do_sc("srlv", ALU_SRLV, 32'h0000_0024, 32'h0000_00F0, 5'd0);
    chk("srlv_res", bus.result, 32'h0000_000F);
    do_sc("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0);
    chk("slt_res", bus.result, 32'h1);
    do_sc("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 0);
    chk("sltu_res", bus.result, 32'h0);
    chk("sltu_zero", bus.zero, 1);
    do_sc("lui", ALU_LUI, 32'h0, 32'h0000_ABCD, 0);
    chk("lui_res", bus.result, 32'hABCD_0000);

    // Multiply: -2 * 3 = -6
    do_md("mult", ALU_MULT, 32'hFFFF_FFFE, 32'h3, 1'b0);
    chk("mult_lo", bus.result, 32'hFFFF_FFFA);
    do_sc("mfhi_mult", ALU_MFHI, 0, 0, 0);
    chk("mfhi_mult_res", bus.result, 32'hFFFF_FFFF);

    // Signed divide with an ignored request injected mid-run
    do_md("div", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1);
    chk("div_lo", bus.result, 32'hFFFF_FFFD);
    do_sc("mfhi_div", ALU_MFHI, 0, 0, 0);
    chk("mfhi_div_res", bus.result, 32'hFFFF_FFFF);

    // Divide by zero
    do_md("divu0", ALU_DIVU, 32'h7, 32'h0, 1'b0);
    chk("divu0_lo", bus.result, 32'hFFFF_FFFF);
    do_sc("mfhi_divu0", ALU_MFHI, 0, 0, 0);
    chk("mfhi_divu0_res", bus.result, 32'h7);

    // Branch compares
    do_sc("beq", ALU_BEQ, 32'h5, 32'h5, 0);
    chk("beq_taken", bus.branch_taken, 1);
    chk("beq_zero", bus.zero, 1);
    do_sc("bne", ALU_BNE, 32'h5, 32'h5, 0);
    chk("bne_taken", bus.branch_taken, 0);
    do_sc("blez", ALU_BLEZ, 32'h0, 32'h0, 0);
    chk("blez_taken", bus.branch_taken, 1);
    do_sc("bgtz", ALU_BGTZ, 32'h8000_0000, 32'h0, 0);
    chk("bgtz_taken", bus.branch_taken, 0);
    chk("bgtz_res", bus.result, 32'h8000_0000);

    // Illegal code leaves HI untouched
    do_sc("ill", 6'b111111, 32'h1, 32'h2, 0);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_res", bus.result, 32'h0);
    do_sc("mfhi_ill", ALU_MFHI, 0, 0, 0);
    chk("mfhi_ill_res", bus.result, 32'h7);
    chk("mfhi_ill_flag", bus.illegal, 0);

    // Abort a DIVU with reset at T+10
    bus.alu_ctrl = ALU_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rdy", bus.in_ready, 1);
    chk("abort_ov", bus.out_valid, 0);
    chk("abort_result", bus.result, 32'h0);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    chk("abort_no_ov", ov_seen, 0);
    do_sc("mfhi_abort", ALU_MFHI, 0, 0, 0);
    chk("mfhi_abort_res", bus.result, 32'h0);
    do_sc("mflo_abort", ALU_MFLO, 0, 0, 0);
    chk("mflo_abort_res", bus.result, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 6-bit ALU control code produced by the ALU control decoder and performs the operation on two 32-bit operands. Single-cycle operations return a registered result one clock after acceptance. MULT/MULTU/DIV/DIVU run as 32-iteration multi-cycle operations into architectural HI/LO registers, with a valid/ready handshake toward the pipeline control.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; `in_valid & in_ready` = accept.
- `alu_ctrl`  in  6  control code, encoded as in `alu_pkg`.
- `op_a`, `op_b`  in  32  rs and rt operand values.
- `shamt`  in  5  shift amount for SLL/SRL/SRA.
- `out_valid`  out  1  one-cycle pulse; result fields valid.
- `result`  out  32  operation result.
- `zero`  out  1  `result == 0`.
- `overflow`  out  1  signed overflow (ADD, SUB only).
- `branch_taken`  out  1  branch condition true (1100xx codes).
- `illegal`  out  1  unrecognised `alu_ctrl`.

## Operation
- Arithmetic and logic codes:
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT (signed), 101011 SLTU.
  - 111000 LUI: result `{op_b[15:0],16'h0}`.
- Shifts: 000000 SLL, 000010 SRL, 000011 SRA use `shamt`. 000100 SLLV, 000110 SRLV, 000111 SRAV use `op_a[4:0]`. All shift `op_b`.
- Branch codes: 110000 BEQ (a==b), 110001 BNE, 110010 BGTZ (signed a>0), 110011 BLEZ (signed a<=0). For these, `result` = `op_a - op_b` and `branch_taken` is set. BLTZ/BGEZ are not in this unit's scope; they are decoded as illegal.
- HI/LO access:
  - 010000 MFHI and 010010 MFLO return HI or LO.
  - 010001 MTHI and 010011 MTLO write `op_a` to HI or LO; result = `op_a`.
- Multiply/divide:
  - 011000 MULT and 011001 MULTU: `{HI,LO}` = 64-bit product.
  - 011010 DIV and 011011 DIVU: LO = quotient, HI = remainder.
  - Signed forms operate on magnitudes and fix signs at the end. The quotient is negative iff the operand signs differ. The remainder takes the sign of the dividend.
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = `op_a`, with normal latency.
  - `result` = new LO.
- Overflow: ADD/SUB set `overflow` and still return the wrapped value; no trap. `overflow` is 0 for all other codes.
- Illegal code: `result` = 0, `illegal` = 1, `out_valid` pulses, HI/LO unchanged.
- FSM states:
  - IDLE → EXEC on accepting a single-cycle code.
  - IDLE → MD_RUN on accepting a mult/div code.
  - EXEC → IDLE after 1 cycle.
  - MD_RUN → MD_FIX when the iteration counter reaches 31.
  - MD_FIX → IDLE after 1 cycle.
  - `in_ready` = 1 only in IDLE.

## Timing
- Reset: all outputs are 0 and HI = LO = 0. The FSM goes to IDLE, the counter to 0, and `in_ready` = 1 from the first cycle after reset.
- Single-cycle op accepted at edge T: `out_valid` high during cycle T+1. `in_ready` is low in T+1 and high again in T+2. Maximum throughput is one op per 2 cycles.
- Mult/div accepted at T:
  - 32 iterations in MD_RUN, cycles T+1..T+32, using a 6-bit counter.
  - Sign fix and HI/LO write in MD_FIX at T+33.
  - `out_valid` in T+34.
- HI/LO update on the same edge that raises `out_valid`. An MFHI issued in the next accepted op sees the new value.
- Operands are captured at accept. Changes on `op_a`/`op_b`/`alu_ctrl` while busy are ignored.
- `in_valid` while `in_ready` = 0 is ignored, not queued.
- `result`, `zero`, `overflow`, `branch_taken` and `illegal` hold their value until the next `out_valid`.
- `rst_n` low mid-operation: abort on the next edge and apply reset values. No `out_valid` is produced for the aborted op.

## Structure
- Package `alu_pkg`:
  - localparams for all control codes above.
  - FSM state enum (IDLE, EXEC, MD_RUN, MD_FIX).
  - `WIDTH` constant.
- Sub-module `muldiv_iter`:
  - shift-add multiplier and restoring divider sharing the 64-bit accumulator and counter.
  - ports: start, signed, is_div, a, b, done, hi, lo.
- Top level holds the FSM, single-cycle datapath, HI/LO and output registers.

## Test plan
- ADD 32'h7FFF_FFFF + 32'h1 → `result` 32'h8000_0000, `overflow` 1, `out_valid` at T+1. ADDU of the same operands → `overflow` 0.
- SRA of 32'h8000_0000 with `shamt` 4 → 32'hF800_0000. SLT of -1 vs 1 → 1; SLTU of the same operands → 0.
- MULT 32'hFFFF_FFFE × 3 → HI 32'hFFFF_FFFF, LO 32'hFFFF_FFFA, `out_valid` at T+34, `in_ready` low T+1..T+34. Follow with MFHI → 32'hFFFF_FFFF.
- DIV -7 / 2 → LO 32'hFFFF_FFFD, HI 32'hFFFF_FFFF. DIVU 7 / 0 → LO 32'hFFFF_FFFF, HI 7.
- BEQ with 5, 5 → `branch_taken` 1, `zero` 1. BLEZ with 0 → `branch_taken` 1. `alu_ctrl` 6'b111111 → `illegal` 1, `result` 0.
- Start DIVU, drop `rst_n` at T+10 → no `out_valid`, HI = LO = 0, `in_ready` 1 after the reset edge. A new `in_valid` during MD_RUN is ignored.
